// File: rtl/ballot_pkg.sv
// Shared types and helpers for the ballot session controller: state encoding,
// default widths, one-hot detection and saturating counter arithmetic.
package ballot_pkg;

    localparam int NUM_CAND_DEF = 4;
    localparam int CNT_W_DEF    = 8;

    typedef enum logic [2:0] {
        ST_CLOSED    = 3'd0,
        ST_OPEN_IDLE = 3'd1,
        ST_ARMED     = 3'd2,
        ST_COMMIT    = 3'd3,
        ST_LOCKOUT   = 3'd4,
        ST_FINAL     = 3'd5
    } state_t;

    // Vectors are zero-extended to 32 bits by the caller, so any width up to 32 works.
    function automatic logic onehot_valid(input logic [31:0] vec);
        return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
    endfunction

    function automatic logic [31:0] sat_max(input int w);
        return 32'hFFFF_FFFF >> (32 - w);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        return (v == sat_max(w)) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/ballot_timer.sv
// Loadable down-counter shared between the ballot timeout and the post-commit
// lockout. Load wins over enable; counting stops at zero.
module ballot_timer #(
    parameter int W = 10
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (enable && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign value = count_reg;
    assign zero  = (count_reg == '0);

endmodule

// File: rtl/ballot_session_ctrl.sv
// Poll session FSM and ballot arbiter: consumes debounced vote pulses, emits a
// single one-hot tally strobe per armed ballot and keeps saturating statistics.
module ballot_session_ctrl
    import ballot_pkg::*;
#(
    parameter int NUM_CAND    = NUM_CAND_DEF,
    parameter int TIMEOUT_CYC = 1000,
    parameter int LOCKOUT_CYC = 10,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                open_poll,
    input  logic                close_poll,
    input  logic                arm_ballot,
    input  logic [NUM_CAND-1:0] vote_valid,
    output logic [NUM_CAND-1:0] tally_inc,
    output logic                ballot_ready,
    output logic                busy,
    output logic                result_mode,
    output logic                close_pending,
    output logic [2:0]          state_o,
    output logic [CNT_W-1:0]    ballots_issued,
    output logic [CNT_W-1:0]    votes_cast,
    output logic [CNT_W-1:0]    rejected
);

    localparam int TMAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]    TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]    LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(sat_max(CNT_W));

    state_t              state_reg, state_next;
    logic [NUM_CAND-1:0] choice_reg, choice_next;
    logic                close_pending_reg, close_pending_next;
    logic [CNT_W-1:0]    ballots_reg, ballots_next;
    logic [CNT_W-1:0]    votes_reg, votes_next;
    logic [CNT_W-1:0]    rejected_reg, rejected_next;

    logic                timer_load;
    logic [TW-1:0]       timer_load_value;
    logic                timer_enable;
    logic [TW-1:0]       timer_value;
    logic                timer_zero;

    logic                vote_any;
    logic                vote_single;

    assign vote_any    = (vote_valid != '0);
    assign vote_single = onehot_valid(32'(vote_valid));

    ballot_timer #(
        .W(TW)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_load_value),
        .enable     (timer_enable),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg         <= ST_CLOSED;
            choice_reg        <= '0;
            close_pending_reg <= 1'b0;
            ballots_reg       <= '0;
            votes_reg         <= '0;
            rejected_reg      <= '0;
        end else begin
            state_reg         <= state_next;
            choice_reg        <= choice_next;
            close_pending_reg <= close_pending_next;
            ballots_reg       <= ballots_next;
            votes_reg         <= votes_next;
            rejected_reg      <= rejected_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        choice_next        = choice_reg;
        close_pending_next = close_pending_reg;
        ballots_next       = ballots_reg;
        votes_next         = votes_reg;
        rejected_next      = rejected_reg;
        timer_load         = 1'b0;
        timer_load_value   = '0;
        timer_enable       = 1'b0;

        case (state_reg)
            ST_CLOSED: begin
                if (open_poll) begin
                    state_next = ST_OPEN_IDLE;
                end
            end

            ST_OPEN_IDLE: begin
                if (vote_any) begin
                    rejected_next = CNT_W'(sat_inc(32'(rejected_reg), CNT_W));
                end
                if (close_poll || close_pending_reg) begin
                    state_next         = ST_FINAL;
                    close_pending_next = 1'b0;
                end else if (arm_ballot && (votes_reg != CNT_MAX)) begin
                    // A full vote counter would hide further votes, so no more ballots.
                    state_next       = ST_ARMED;
                    ballots_next     = CNT_W'(sat_inc(32'(ballots_reg), CNT_W));
                    timer_load       = 1'b1;
                    timer_load_value = TIMEOUT_LOAD;
                end
            end

            ST_ARMED: begin
                timer_enable = 1'b1;
                if (close_poll) begin
                    close_pending_next = 1'b1;
                end
                // A valid vote wins over a timeout landing in the same cycle.
                if (vote_single) begin
                    choice_next = vote_valid;
                    state_next  = ST_COMMIT;
                end else begin
                    if (vote_any) begin
                        rejected_next = CNT_W'(sat_inc(32'(rejected_reg), CNT_W));
                    end
                    if (timer_zero) begin
                        state_next = ST_OPEN_IDLE;
                    end
                end
            end

            ST_COMMIT: begin
                if (close_poll) begin
                    close_pending_next = 1'b1;
                end
                votes_next       = CNT_W'(sat_inc(32'(votes_reg), CNT_W));
                timer_load       = 1'b1;
                timer_load_value = LOCKOUT_LOAD;
                state_next       = ST_LOCKOUT;
            end

            ST_LOCKOUT: begin
                timer_enable = 1'b1;
                if (close_poll) begin
                    close_pending_next = 1'b1;
                end
                if (timer_zero) begin
                    state_next = ST_OPEN_IDLE;
                end
            end

            ST_FINAL: begin
                state_next = ST_FINAL;
            end

            default: begin
                state_next = ST_CLOSED;
            end
        endcase
    end

    always_comb begin
        ballot_ready   = 1'b0;
        busy           = 1'b0;
        result_mode    = 1'b0;
        close_pending  = close_pending_reg;
        state_o        = state_reg;
        ballots_issued = ballots_reg;
        votes_cast     = votes_reg;
        rejected       = rejected_reg;
        case (state_reg)
            ST_ARMED:   ballot_ready = 1'b1;
            ST_COMMIT:  busy         = 1'b1;
            ST_LOCKOUT: busy         = 1'b1;
            ST_FINAL:   result_mode  = 1'b1;
            default:    ;
        endcase
    end

    // The strobe is derived only from registers, so it can never be multi-hot.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CAND; gi++) begin : g_tally
            assign tally_inc[gi] = (state_reg == ST_COMMIT) && choice_reg[gi];
        end
    endgenerate

endmodule
